// File: rtl/lpf_ser_pkg.sv
// Shared types and constants for the LPF serial programming port.
package lpf_ser_pkg;

  // Frame is {pd, fc[7:0]}, shifted MSB first.
  localparam int unsigned LPF_FRAME_W = 9;

  // Serialiser FSM states.
  typedef enum logic [1:0] {
    LPF_SER_IDLE  = 2'd0,
    LPF_SER_SETUP = 2'd1,
    LPF_SER_HIGH  = 2'd2,
    LPF_SER_LATCH = 2'd3
  } lpf_ser_state_t;

  // Assemble the frame from the control-register outputs.
  function automatic logic [LPF_FRAME_W-1:0] lpf_pack(input logic pd, input logic [7:0] fc);
    return {pd, fc};
  endfunction

endpackage

// File: rtl/lpf_tick.sv
// Half-period divider: counts while enabled, wraps to 0 at CLK_DIV-1 and
// flags that cycle as a tick. Clear holds the count at 0.
module lpf_tick #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DIV_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [DIV_W-1:0] TERM = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  assign tick = en && (div_cnt == TERM);

  // Divider counter with clear and terminal-count wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (en) begin
      if (div_cnt == TERM) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lpf_ser.sv
// Serial programming port for the analog LPF tuning latch. Sends {pd,fc}
// MSB first over sclk/sdo/sle after reset and whenever the value differs
// from the last frame sent.
module lpf_ser
  import lpf_ser_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DIV_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pd,
  input  logic [7:0] fc,
  output logic       sclk,
  output logic       sdo,
  output logic       sle,
  output logic       busy,
  output logic       done
);

  lpf_ser_state_t state, state_nxt;

  logic [LPF_FRAME_W-1:0] shreg, shreg_nxt;
  logic [LPF_FRAME_W-1:0] shadow, shadow_nxt;
  logic                   sent, sent_nxt;
  logic [3:0]             bit_cnt, bit_cnt_nxt;

  logic [LPF_FRAME_W-1:0] frame_in;
  logic                   pending;
  logic                   tick;
  logic                   div_clr;

  logic sclk_nxt, sdo_nxt, sle_nxt, busy_nxt, done_nxt;

  assign frame_in = lpf_pack(pd, fc);
  assign pending  = !sent || (frame_in != shadow);

  // The divider rests at 0 in IDLE, so every state is entered with a fresh count.
  assign div_clr = (state == LPF_SER_IDLE);

  lpf_tick #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .en   (!div_clr),
    .tick (tick)
  );

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    shadow_nxt  = shadow;
    sent_nxt    = sent;
    bit_cnt_nxt = bit_cnt;

    unique case (state)
      LPF_SER_IDLE: begin
        if (pending) begin
          shreg_nxt   = frame_in;
          shadow_nxt  = frame_in;
          sent_nxt    = 1'b1;
          bit_cnt_nxt = 4'd8;
          state_nxt   = LPF_SER_SETUP;
        end
      end
      LPF_SER_SETUP: begin
        if (tick) begin
          state_nxt = LPF_SER_HIGH;
        end
      end
      LPF_SER_HIGH: begin
        if (tick) begin
          if (bit_cnt == 4'd0) begin
            state_nxt = LPF_SER_LATCH;
          end else begin
            shreg_nxt   = {shreg[LPF_FRAME_W-2:0], 1'b0};
            bit_cnt_nxt = bit_cnt - 4'd1;
            state_nxt   = LPF_SER_SETUP;
          end
        end
      end
      LPF_SER_LATCH: begin
        if (tick) begin
          state_nxt = LPF_SER_IDLE;
        end
      end
      default: begin
        state_nxt = LPF_SER_IDLE;
      end
    endcase

    // Outputs are decoded from the upcoming state so that, once registered,
    // they line up with the state they describe.
    sclk_nxt = (state_nxt == LPF_SER_HIGH);
    sdo_nxt  = ((state_nxt == LPF_SER_SETUP) || (state_nxt == LPF_SER_HIGH))
               ? shreg_nxt[LPF_FRAME_W-1] : 1'b0;
    sle_nxt  = (state_nxt == LPF_SER_LATCH);
    busy_nxt = (state_nxt != LPF_SER_IDLE);
    done_nxt = (state == LPF_SER_LATCH) && (state_nxt == LPF_SER_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= LPF_SER_IDLE;
      shreg   <= '0;
      shadow  <= '0;
      sent    <= 1'b0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      sdo     <= 1'b0;
      sle     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      shadow  <= shadow_nxt;
      sent    <= sent_nxt;
      bit_cnt <= bit_cnt_nxt;
      sclk    <= sclk_nxt;
      sdo     <= sdo_nxt;
      sle     <= sle_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_lpf_ser.sv
// Scoreboard bench for lpf_ser: instance 0 uses CLK_DIV=4, instance 1 CLK_DIV=1.
module tb_lpf_ser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b1, rst1 = 1'b1;
  logic       pd0 = 1'b0, pd1 = 1'b0;
  logic [7:0] fc0 = '0, fc1 = '0;
  logic       sclk0, sdo0, sle0, busy0, done0;
  logic       sclk1, sdo1, sle1, busy1, done1;

  lpf_ser #(.CLK_DIV(4), .DIV_W(8)) u_dut0 (
    .clk(clk), .rst(rst0), .pd(pd0), .fc(fc0),
    .sclk(sclk0), .sdo(sdo0), .sle(sle0), .busy(busy0), .done(done0)
  );

  lpf_ser #(.CLK_DIV(1), .DIV_W(8)) u_dut1 (
    .clk(clk), .rst(rst1), .pd(pd1), .fc(fc1),
    .sclk(sclk1), .sdo(sdo1), .sle(sle1), .busy(busy1), .done(done1)
  );

  logic [1:0] rst_w, sclk_w, sdo_w, sle_w, busy_w, done_w;
  assign rst_w  = {rst1, rst0};
  assign sclk_w = {sclk1, sclk0};
  assign sdo_w  = {sdo1, sdo0};
  assign sle_w  = {sle1, sle0};
  assign busy_w = {busy1, busy0};
  assign done_w = {done1, done0};

  int checks = 0;
  int errors = 0;

  logic [8:0] exp0[$];
  logic [8:0] exp1[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor state, one slot per instance.
  int         cdiv[2] = '{4, 1};
  int         cyc = 0;
  int         nbits[2], frames[2], edges[2], sle_cnt[2];
  int         last_rise[2], busy_rise[2], gap[2];
  int         last_done[2] = '{-1000, -1000};
  logic [8:0] acc[2];
  logic       prev_sclk[2], prev_busy[2], prev_sdo[2], prev_done[2], unstable[2];

  // Monitor: rebuilds frames from sclk rising edges and scores them on done.
  always @(negedge clk) begin
    logic [8:0] e;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst_w[i]) begin
        nbits[i] = 0; acc[i] = '0; sle_cnt[i] = 0; unstable[i] = 1'b0;
        prev_sclk[i] = 1'b0; prev_busy[i] = 1'b0; prev_sdo[i] = 1'b0; prev_done[i] = 1'b0;
      end else begin
        if (prev_done[i]) chk($sformatf("done_pulse%0d", i), int'(done_w[i]), 0);
        if (busy_w[i] && !prev_busy[i]) begin
          busy_rise[i] = cyc; gap[i] = cyc - last_done[i];
          nbits[i] = 0; acc[i] = '0; sle_cnt[i] = 0; unstable[i] = 1'b0;
        end
        if (sclk_w[i] && !prev_sclk[i]) begin
          if (nbits[i] > 0) chk($sformatf("sclk_period%0d", i), cyc - last_rise[i], 2 * cdiv[i]);
          last_rise[i] = cyc;
          acc[i] = {acc[i][7:0], sdo_w[i]};
          nbits[i]++;
          edges[i]++;
        end
        if (sclk_w[i] && prev_sclk[i] && (sdo_w[i] != prev_sdo[i])) unstable[i] = 1'b1;
        if (sle_w[i]) sle_cnt[i]++;
        if (done_w[i]) begin
          last_done[i] = cyc;
          frames[i]++;
          if (i == 0 && exp0.size() > 0) begin
            e = exp0.pop_front();
          end else if (i == 1 && exp1.size() > 0) begin
            e = exp1.pop_front();
          end else begin
            e = 9'bx;
          end
          if ($isunknown(e)) begin
            chk($sformatf("unexpected_frame%0d", i), int'(acc[i]), -1);
          end else begin
            chk($sformatf("frame%0d", i), int'(acc[i]), int'(e));
            chk($sformatf("nbits%0d", i), nbits[i], 9);
            chk($sformatf("sle_len%0d", i), sle_cnt[i], cdiv[i]);
            chk($sformatf("done_latency%0d", i), cyc - busy_rise[i], 19 * cdiv[i]);
            chk($sformatf("sdo_stable%0d", i), int'(unstable[i]), 0);
          end
        end
        prev_sclk[i] = sclk_w[i];
        prev_busy[i] = busy_w[i];
        prev_sdo[i]  = sdo_w[i];
        prev_done[i] = done_w[i];
      end
    end
  end

  task automatic wait_frames(input int i, input int target, input int budget);
    int k = 0;
    while (frames[i] < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk($sformatf("frames_reached%0d", i), frames[i], target);
  endtask

  task automatic wait_bits(input int n, input int budget);
    int k = 0;
    while (nbits[0] < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("bits_reached", int'(nbits[0] >= n), 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e0;
    // Reset state of both instances.
    #2;
    chk("rst_sclk", int'(sclk_w), 0);
    chk("rst_sdo",  int'(sdo_w),  0);
    chk("rst_sle",  int'(sle_w),  0);
    chk("rst_busy", int'(busy_w), 0);
    chk("rst_done", int'(done_w), 0);
    repeat (3) step();

    // 1: first frame after reset, then silence.
    exp0.push_back(9'h000);
    rst0 = 1'b0;
    wait_frames(0, 1, 200);
    e0 = edges[0];
    repeat (200) step();
    chk("idle_no_edges", edges[0], e0);
    chk("idle_busy", int'(busy0), 0);

    // 2: new cutoff code.
    exp0.push_back(9'h0A5);
    fc0 = 8'hA5;
    wait_frames(0, 2, 200);

    // 3: change during bit 3; second frame captured in the done cycle.
    repeat (5) step();
    exp0.push_back(9'h001);
    fc0 = 8'h01;
    repeat (3) step();
    wait_bits(3, 200);
    exp0.push_back(9'h002);
    fc0 = 8'h02;
    wait_frames(0, 4, 300);
    chk("back_to_back_gap", gap[0], 1);
    repeat (20) step();
    chk("t3_frame_count", frames[0], 4);

    // 4: change then revert mid-frame.
    exp0.push_back(9'h010);
    fc0 = 8'h10;
    wait_frames(0, 5, 200);
    repeat (5) step();
    exp0.push_back(9'h020);
    fc0 = 8'h20;
    repeat (3) step();
    wait_bits(4, 200);
    exp0.push_back(9'h010);
    fc0 = 8'h10;
    wait_frames(0, 7, 300);
    repeat (20) step();
    chk("t4_frame_count", frames[0], 7);

    // 5: asynchronous reset during bit 5, then full re-send.
    exp0.push_back(9'h1C3);
    pd0 = 1'b1;
    fc0 = 8'hC3;
    repeat (3) step();
    wait_bits(5, 200);
    @(posedge clk);
    #2;
    rst0 = 1'b1;
    #1;
    chk("abort_sclk", int'(sclk0), 0);
    chk("abort_sdo",  int'(sdo0),  0);
    chk("abort_sle",  int'(sle0),  0);
    chk("abort_busy", int'(busy0), 0);
    chk("abort_done", int'(done0), 0);
    repeat (3) step();
    rst0 = 1'b0;
    wait_frames(0, 8, 200);
    repeat (100) step();
    chk("t5_frame_count", frames[0], 8);

    // 6: CLK_DIV=1 instance.
    pd1 = 1'b1;
    fc1 = 8'hFF;
    exp1.push_back(9'h1FF);
    rst1 = 1'b0;
    wait_frames(1, 1, 100);
    repeat (30) step();
    chk("t6_frame_count", frames[1], 1);

    chk("exp0_drained", exp0.size(), 0);
    chk("exp1_drained", exp1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
